// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the fetch (I) and
// memory (D) stages. One transaction in flight at a time. D has priority,
// capped by a fairness counter. A watchdog aborts transactions that never ack.
module mem_port_arbiter #(
  parameter int XLEN       = 32,
  parameter int FAIR_LIMIT = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            IReq,
  input  logic [XLEN-1:0] IAddr,
  output logic [XLEN-1:0] IRdata,
  output logic            IDone,
  input  logic            DReq,
  input  logic            DWe,
  input  logic [XLEN-1:0] DAddr,
  input  logic [XLEN-1:0] DWdata,
  output logic [XLEN-1:0] DRdata,
  output logic            DDone,
  output logic            MemReq,
  output logic            MemWe,
  output logic [XLEN-1:0] MemAddr,
  output logic [XLEN-1:0] MemWdata,
  input  logic [XLEN-1:0] MemRdata,
  input  logic            MemAck,
  output logic            BusErr
);

  localparam int FAIR_W = $clog2(FAIR_LIMIT + 1);
  localparam int WD_W   = $clog2(TIMEOUT + 1);
  localparam logic [FAIR_W-1:0] FAIR_MAX = FAIR_W'(FAIR_LIMIT);
  // Last BUSY cycle allowed without an ack; no ack here means abort.
  localparam logic [WD_W-1:0]   WD_LAST  = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BUSY_I = 2'd1,
    S_BUSY_D = 2'd2
  } state_t;

  state_t              r_state, w_next_state;
  logic                r_mem_req, w_mem_req;
  logic                r_mem_we, w_mem_we;
  logic [XLEN-1:0]     r_mem_addr, w_mem_addr;
  logic [XLEN-1:0]     r_mem_wdata, w_mem_wdata;
  logic [XLEN-1:0]     r_irdata, w_irdata;
  logic [XLEN-1:0]     r_drdata, w_drdata;
  logic                r_idone, w_idone;
  logic                r_ddone, w_ddone;
  logic                r_buserr, w_buserr;
  logic [FAIR_W-1:0]   r_fair_cnt, w_fair_cnt;
  logic [WD_W-1:0]     r_wd_cnt, w_wd_cnt;
  logic                w_d_wins, w_grant_d, w_grant_i;

  // State and output registers; reset drops MemReq immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_irdata    <= '0;
      r_drdata    <= '0;
      r_idone     <= 1'b0;
      r_ddone     <= 1'b0;
      r_buserr    <= 1'b0;
      r_fair_cnt  <= '0;
      r_wd_cnt    <= '0;
    end else begin
      r_state     <= w_next_state;
      r_mem_req   <= w_mem_req;
      r_mem_we    <= w_mem_we;
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
      r_irdata    <= w_irdata;
      r_drdata    <= w_drdata;
      r_idone     <= w_idone;
      r_ddone     <= w_ddone;
      r_buserr    <= w_buserr;
      r_fair_cnt  <= w_fair_cnt;
      r_wd_cnt    <= w_wd_cnt;
    end
  end

  // Arbitration, fairness, watchdog and next-state/next-output logic.
  always_comb begin
    w_next_state = r_state;
    w_mem_req    = r_mem_req;
    w_mem_we     = r_mem_we;
    w_mem_addr   = r_mem_addr;
    w_mem_wdata  = r_mem_wdata;
    w_irdata     = r_irdata;
    w_drdata     = r_drdata;
    w_idone      = 1'b0;
    w_ddone      = 1'b0;
    w_buserr     = r_buserr;
    w_fair_cnt   = r_fair_cnt;
    w_wd_cnt     = r_wd_cnt;

    // Arbitrate on the raw requests, then suppress the grant if the winner is
    // still showing Done: its Req belongs to the access that just finished.
    // When D still claims priority in its Done cycle the slot stays empty
    // rather than passing to I, so back-to-back D traffic counts toward the
    // fairness limit instead of strictly alternating.
    w_d_wins  = DReq & (~IReq | (r_fair_cnt < FAIR_MAX));
    w_grant_d = (r_state == S_IDLE) & w_d_wins & ~r_ddone;
    w_grant_i = (r_state == S_IDLE) & ~w_d_wins & IReq & ~r_idone;

    if (!IReq || w_grant_i) begin
      w_fair_cnt = '0;
    end else if (w_grant_d && (r_fair_cnt < FAIR_MAX)) begin
      w_fair_cnt = r_fair_cnt + FAIR_W'(1);
    end

    case (r_state)
      S_IDLE: begin
        if (w_grant_d) begin
          w_mem_req    = 1'b1;
          w_mem_we     = DWe;
          w_mem_addr   = DAddr;
          w_mem_wdata  = DWdata;
          w_wd_cnt     = '0;
          w_next_state = S_BUSY_D;
        end else if (w_grant_i) begin
          w_mem_req    = 1'b1;
          w_mem_we     = 1'b0;
          w_mem_addr   = IAddr;
          w_mem_wdata  = '0;
          w_wd_cnt     = '0;
          w_next_state = S_BUSY_I;
        end
      end
      S_BUSY_I, S_BUSY_D: begin
        // An ack on the final allowed cycle still completes normally.
        if (MemAck) begin
          w_mem_req    = 1'b0;
          w_next_state = S_IDLE;
          if (r_state == S_BUSY_I) begin
            w_irdata = MemRdata;
            w_idone  = 1'b1;
          end else begin
            if (!r_mem_we) w_drdata = MemRdata;
            w_ddone = 1'b1;
          end
        end else if (r_wd_cnt == WD_LAST) begin
          w_mem_req    = 1'b0;
          w_buserr     = 1'b1;
          w_next_state = S_IDLE;
          if (r_state == S_BUSY_I) begin
            w_irdata = '0;
            w_idone  = 1'b1;
          end else begin
            w_drdata = '0;
            w_ddone  = 1'b1;
          end
        end else begin
          w_wd_cnt = r_wd_cnt + WD_W'(1);
        end
      end
      default: begin
        w_mem_req    = 1'b0;
        w_next_state = S_IDLE;
      end
    endcase
  end

  assign IRdata   = r_irdata;
  assign IDone    = r_idone;
  assign DRdata   = r_drdata;
  assign DDone    = r_ddone;
  assign MemReq   = r_mem_req;
  assign MemWe    = r_mem_we;
  assign MemAddr  = r_mem_addr;
  assign MemWdata = r_mem_wdata;
  assign BusErr   = r_buserr;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: expected memory requests and expected
// completions are queued as stimulus is driven and compared as the DUT emits them.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        IReq;
  logic [31:0] IAddr;
  logic [31:0] IRdata;
  logic        IDone;
  logic        DReq;
  logic        DWe;
  logic [31:0] DAddr;
  logic [31:0] DWdata;
  logic [31:0] DRdata;
  logic        DDone;
  logic        MemReq;
  logic        MemWe;
  logic [31:0] MemAddr;
  logic [31:0] MemWdata;
  logic [31:0] MemRdata;
  logic        MemAck;
  logic        BusErr;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic        is_d;
    logic [31:0] data;
    logic        err;
  } done_t;

  req_t  req_q[$];
  done_t done_q[$];
  int    vectors;
  int    miscompares;

  mem_port_arbiter #(
    .XLEN(32),
    .FAIR_LIMIT(4),
    .TIMEOUT(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .IReq(IReq),
    .IAddr(IAddr),
    .IRdata(IRdata),
    .IDone(IDone),
    .DReq(DReq),
    .DWe(DWe),
    .DAddr(DAddr),
    .DWdata(DWdata),
    .DRdata(DRdata),
    .DDone(DDone),
    .MemReq(MemReq),
    .MemWe(MemWe),
    .MemAddr(MemAddr),
    .MemWdata(MemWdata),
    .MemRdata(MemRdata),
    .MemAck(MemAck),
    .BusErr(BusErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
    $display("check %-16s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // Act as the memory: wait for MemReq, compare it with the next expected
  // request, then optionally ack after 'delay' further cycles.
  task automatic serve(input int delay, input logic [31:0] rdata, input bit do_ack);
    int   n;
    req_t e;
    n = 0;
    while (MemReq !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("memreq_seen", 32'(MemReq), 32'd1);
    e = (req_q.size() != 0) ? req_q.pop_front() : '0;
    chk("mem_addr", MemAddr, e.addr);
    chk("mem_we", 32'(MemWe), 32'(e.we));
    if (e.we) chk("mem_wdata", MemWdata, e.wdata);
    if (do_ack) begin
      repeat (delay) @(negedge clk);
      chk("memreq_held", 32'(MemReq), 32'd1);
      chk("memaddr_held", MemAddr, e.addr);
      MemAck   = 1'b1;
      MemRdata = rdata;
      @(negedge clk);
      MemAck   = 1'b0;
      MemRdata = 32'hDEAD_BEEF;
    end
  endtask

  // Wait for a Done pulse, compare it with the next expected completion,
  // optionally drop requests in the Done cycle, then confirm the pulse ends.
  task automatic wait_done(input bit drop_i, input bit drop_d, output int lat);
    int    n;
    done_t e;
    n = 0;
    while (!(IDone | DDone) && n < 40) begin
      @(negedge clk);
      n++;
    end
    lat = n;
    e = (done_q.size() != 0) ? done_q.pop_front() : '0;
    chk("done_side", {30'd0, DDone, IDone}, e.is_d ? 32'd2 : 32'd1);
    chk("done_data", e.is_d ? DRdata : IRdata, e.data);
    chk("buserr", 32'(BusErr), 32'(e.err));
    chk("memreq_low", 32'(MemReq), 32'd0);
    if (drop_i) IReq = 1'b0;
    if (drop_d) DReq = 1'b0;
    @(negedge clk);
    chk("done_pulse", {30'd0, DDone, IDone}, 32'd0);
  endtask

  initial begin
    int lat;
    vectors     = 0;
    miscompares = 0;
    reset    = 1'b0;
    IReq     = 1'b0;
    IAddr    = '0;
    DReq     = 1'b0;
    DWe      = 1'b0;
    DAddr    = '0;
    DWdata   = '0;
    MemRdata = '0;
    MemAck   = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_memreq", 32'(MemReq), 32'd0);
    chk("rst_done", {30'd0, DDone, IDone}, 32'd0);
    chk("rst_buserr", 32'(BusErr), 32'd0);
    chk("rst_memaddr", MemAddr, 32'd0);
    chk("rst_drdata", DRdata, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // MemAck while idle is ignored
    MemAck = 1'b1;
    MemRdata = 32'h1234_5678;
    @(negedge clk);
    MemAck = 1'b0;
    @(negedge clk);
    chk("idle_ack_done", {30'd0, DDone, IDone}, 32'd0);
    chk("idle_ack_req", 32'(MemReq), 32'd0);

    // Fetch 0x100, ack two cycles after MemReq
    req_q.push_back('{we: 1'b0, addr: 32'h100, wdata: 32'h0});
    done_q.push_back('{is_d: 1'b0, data: 32'h0050_0093, err: 1'b0});
    IAddr = 32'h100;
    IReq  = 1'b1;
    serve(2, 32'h0050_0093, 1'b1);
    wait_done(1'b1, 1'b0, lat);

    // Plain load to give DRdata a known value
    req_q.push_back('{we: 1'b0, addr: 32'h3000, wdata: 32'h0});
    done_q.push_back('{is_d: 1'b1, data: 32'h1122_3344, err: 1'b0});
    DAddr = 32'h3000;
    DWe   = 1'b0;
    DReq  = 1'b1;
    serve(0, 32'h1122_3344, 1'b1);
    wait_done(1'b0, 1'b1, lat);

    // Simultaneous store and fetch: store first, DRdata untouched, then fetch
    req_q.push_back('{we: 1'b1, addr: 32'h2000, wdata: 32'hCAFE_F00D});
    req_q.push_back('{we: 1'b0, addr: 32'h104, wdata: 32'h0});
    done_q.push_back('{is_d: 1'b1, data: 32'h1122_3344, err: 1'b0});
    done_q.push_back('{is_d: 1'b0, data: 32'h0000_0013, err: 1'b0});
    IAddr  = 32'h104;
    DAddr  = 32'h2000;
    DWe    = 1'b1;
    DWdata = 32'hCAFE_F00D;
    IReq   = 1'b1;
    DReq   = 1'b1;
    serve(1, 32'h55AA_55AA, 1'b1);
    wait_done(1'b0, 1'b1, lat);
    DWe = 1'b0;
    serve(0, 32'h0000_0013, 1'b1);
    wait_done(1'b1, 1'b0, lat);

    // Fairness: both held high, expect D,D,D,D,I,D
    IAddr = 32'h200;
    DAddr = 32'h4000;
    for (int k = 0; k < 4; k++) begin
      req_q.push_back('{we: 1'b0, addr: 32'h4000 + 32'(4 * k), wdata: 32'h0});
      done_q.push_back('{is_d: 1'b1, data: 32'hD000_0000 + 32'(k), err: 1'b0});
    end
    req_q.push_back('{we: 1'b0, addr: 32'h200, wdata: 32'h0});
    done_q.push_back('{is_d: 1'b0, data: 32'h0000_0113, err: 1'b0});
    req_q.push_back('{we: 1'b0, addr: 32'h4010, wdata: 32'h0});
    done_q.push_back('{is_d: 1'b1, data: 32'hD000_0004, err: 1'b0});
    IReq = 1'b1;
    DReq = 1'b1;
    for (int k = 0; k < 4; k++) begin
      serve(0, 32'hD000_0000 + 32'(k), 1'b1);
      DAddr = DAddr + 32'd4;
      wait_done(1'b0, 1'b0, lat);
    end
    serve(0, 32'h0000_0113, 1'b1);
    wait_done(1'b0, 1'b0, lat);
    serve(0, 32'hD000_0004, 1'b1);
    wait_done(1'b1, 1'b1, lat);

    // Watchdog: load never acked, abort 8 cycles after MemReq rises
    req_q.push_back('{we: 1'b0, addr: 32'h5000, wdata: 32'h0});
    done_q.push_back('{is_d: 1'b1, data: 32'h0, err: 1'b1});
    DAddr = 32'h5000;
    DReq  = 1'b1;
    serve(0, 32'h0, 1'b0);
    wait_done(1'b0, 1'b1, lat);
    chk("timeout_latency", 32'(lat), 32'd8);

    // BusErr stays set through a good access
    req_q.push_back('{we: 1'b0, addr: 32'h300, wdata: 32'h0});
    done_q.push_back('{is_d: 1'b0, data: 32'h0000_0777, err: 1'b1});
    IAddr = 32'h300;
    IReq  = 1'b1;
    serve(3, 32'h0000_0777, 1'b1);
    wait_done(1'b1, 1'b0, lat);

    // Asynchronous reset in the middle of a D transaction
    req_q.push_back('{we: 1'b0, addr: 32'h6000, wdata: 32'h0});
    DAddr = 32'h6000;
    DReq  = 1'b1;
    serve(0, 32'h0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("async_memreq", 32'(MemReq), 32'd0);
    chk("async_ddone", 32'(DDone), 32'd0);
    chk("async_buserr", 32'(BusErr), 32'd0);
    DReq = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_memreq", 32'(MemReq), 32'd0);

    // Ack on the exact timeout cycle: normal completion, no error
    req_q.push_back('{we: 1'b0, addr: 32'h7000, wdata: 32'h0});
    done_q.push_back('{is_d: 1'b1, data: 32'hABCD_1234, err: 1'b0});
    DAddr = 32'h7000;
    DReq  = 1'b1;
    serve(7, 32'hABCD_1234, 1'b1);
    wait_done(1'b0, 1'b1, lat);
    chk("edge_ack_latency", 32'(lat), 32'd0);
    @(negedge clk);
    chk("final_buserr", 32'(BusErr), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
